// File: rtl/key_scanner_poly.sv
`default_nettype none
// ============================================================================
//  Module   : key_scanner_poly
//  Brief    : Polyphonic keyboard scanner. Synchronises and debounces each
//             key, drives a per-key half-period for the tone generators and
//             queues ASCII press/release events into a small framed FIFO.
//  Revision : 1.0
// ============================================================================
module key_scanner_poly #(
    parameter int NUM_KEYS        = 13,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 8,
    parameter int REL_EVENTS      = 1,
    parameter logic [NUM_KEYS-1:0][31:0] BASE_PERIOD = {
        32'd95556,  32'd101238, 32'd107258, 32'd113636, 32'd120394,
        32'd127553, 32'd135137, 32'd143173, 32'd151686, 32'd160706,
        32'd170262, 32'd180387, 32'd191113},
    parameter logic [NUM_KEYS-1:0][7:0] KEY_CODE = {
        8'h43, 8'h42, 8'h61, 8'h41, 8'h67, 8'h47, 8'h66,
        8'h46, 8'h45, 8'h64, 8'h44, 8'h63, 8'h43}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_KEYS-1:0]           KEYBOARD,
    input  logic [2:0]                    octave,
    output logic [NUM_KEYS-1:0][31:0]     noteFrequency,
    output logic [9:0]                    frame_data,
    output logic                          frame_valid,
    input  logic                          frame_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    LED
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_CYCLES);
    localparam logic [AW:0]   FIFO_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [9:0]    IDLE_FRAME = 10'b1_0000_0000_0;

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] stable_q, stable_d;
    logic [CW-1:0]       cnt_q [NUM_KEYS];
    logic [CW-1:0]       cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_edge, rel_edge;
    logic [NUM_KEYS-1:0] press_q, press_d, rel_q, rel_d;
    logic                lost_q, lost_d;

    logic                sel_found;
    logic                sel_rel;
    logic [KW-1:0]       sel_idx;
    logic [7:0]          push_code;
    logic                push, pop, full;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [AW:0]         count_q;

    logic [NUM_KEYS-1:0][31:0] nf_q;
    logic                run_q, idle_q;
    logic [2:0]          oct_q;

    // Two-flop synchroniser on every raw key level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= KEYBOARD;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a key must disagree with its stable level for long enough
    // before the stable level follows; any agreement restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        press_edge = stable_d & ~stable_q;
        rel_edge   = (REL_EVENTS != 0) ? (~stable_d & stable_q) : '0;
    end

    // Pick the lowest-numbered key with a pending event, press first.
    always_comb begin
        sel_found = 1'b0;
        sel_rel   = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (press_q[i] | rel_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = KW'(i);
                sel_rel   = ~press_q[i];
            end
        end
        push_code = KEY_CODE[sel_idx] | (sel_rel ? 8'h80 : 8'h00);
    end

    assign frame_valid = (count_q != '0);
    assign pop         = frame_valid & frame_ready;
    assign full        = (count_q == FIFO_FULL);
    // A full FIFO still accepts an event in the same cycle it releases one.
    assign push        = sel_found & (~full | pop);

    // Pending-event bookkeeping: retire the enqueued bit, flag overwritten
    // events, then record new edges (a new edge cancels the opposite one).
    always_comb begin
        press_d = press_q;
        rel_d   = rel_q;
        if (push) begin
            if (sel_rel) begin
                rel_d[sel_idx] = 1'b0;
            end else begin
                press_d[sel_idx] = 1'b0;
            end
        end
        lost_d  = lost_q | (|(press_edge & press_d)) | (|(rel_edge & rel_d));
        press_d = (press_d | press_edge) & ~rel_edge;
        rel_d   = (rel_d | rel_edge) & ~press_edge;
    end

    // Debounce state, pending bits and FIFO pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            press_q  <= '0;
            rel_q    <= '0;
            lost_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            lost_q   <= lost_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents are only visible while the count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    // Tone periods and status register.
    always_ff @(posedge clk) begin
        if (reset) begin
            nf_q   <= '0;
            run_q  <= 1'b0;
            idle_q <= 1'b0;
            oct_q  <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                nf_q[i] <= stable_q[i] ? (BASE_PERIOD[i] >> octave) : 32'd0;
            end
            run_q  <= 1'b1;
            idle_q <= ~|stable_q;
            oct_q  <= octave;
        end
    end

    assign frame_data    = frame_valid ? {1'b1, mem_q[rd_ptr_q], 1'b0} : IDLE_FRAME;
    assign fifo_count    = count_q;
    assign noteFrequency = nf_q;
    assign LED           = {run_q, idle_q, lost_q, 2'b00, oct_q};

endmodule
`default_nettype wire

// File: doc/key_scanner_poly.md
KEY_SCANNER_POLY -- requirements
Module: key_scanner_poly

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 13: number of keyboard inputs (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles before a key change is accepted (>=2).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter REL_EVENTS, default 1: 1 enqueues press and release events, 0 enqueues press only.
REQ-005 SHALL have parameter BASE_PERIOD [NUM_KEYS][32], default idx0..12 = 191113,180387,170262,160706,151686,143173,135137,127553,120394,113636,107258,101238,95556: per-key half-period at octave 0.
REQ-006 SHALL have parameter KEY_CODE [NUM_KEYS][8], default idx0..12 = 43,63,44,64,45,46,66,47,67,41,61,42,43 (hex): per-key ASCII code.
REQ-007 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-008 SHALL have ports: reset  in  1  synchronous active-high reset.
REQ-009 SHALL have ports: KEYBOARD  in  NUM_KEYS  raw asynchronous key levels, 1 = pressed.
REQ-010 SHALL have ports: octave  in  3  right-shift applied to BASE_PERIOD.
REQ-011 SHALL have ports: noteFrequency  out  NUM_KEYS x 32  per-key half-period, 0 = silent.
REQ-012 SHALL have ports: frame_data  out  10  {stop=1, code[7:0], start=0}.
REQ-013 SHALL have ports: frame_valid  out  1; frame_ready  in  1; fifo_count  out  clog2(FIFO_DEPTH)+1.
REQ-014 SHALL have ports: LED  out  8  status.

Function
REQ-015 SHALL pass each KEYBOARD bit through a 2-flop synchroniser before any other use.
REQ-016 SHALL keep per key a stable state and counter: counter increments while synced != stable, clears when equal; at DEBOUNCE_CYCLES stable takes synced value and counter clears.
REQ-017 SHALL flag a press edge on stable 0->1 and a release edge on stable 1->0 (release ignored when REL_EVENTS=0).
REQ-018 SHALL hold per-key press_pend and rel_pend bits; a new edge sets its bit and clears the opposite bit of the same key.
REQ-019 SHALL set sticky LED[5] when an edge arrives for a key whose same-type pend bit is already set (lost event).
REQ-020 SHALL enqueue at most one event per cycle when FIFO not full: lowest-index key with any pend bit; press before release; the enqueued bit clears.
REQ-021 SHALL encode press code as KEY_CODE[i] and release code as KEY_CODE[i] | 8'h80.
REQ-022 SHALL present FIFO head on frame_data with frame_valid=1 whenever fifo_count>0; pop on frame_valid & frame_ready.
REQ-023 SHALL hold frame_data stable while frame_valid=1 and frame_ready=0.
REQ-024 SHALL allow simultaneous push and pop when full or empty-with-push; count unchanged on simultaneous push+pop; pointers wrap modulo FIFO_DEPTH.
REQ-025 SHALL leave pend bits set while FIFO full; no event is dropped for fullness.
REQ-026 SHALL register noteFrequency[i] = BASE_PERIOD[i] >> octave when stable[i]=1, else 0; one cycle after the stable change or octave change.
REQ-027 SHALL drive LED[7]=1 when out of reset, LED[6]=1 when no stable key is held, LED[5] lost-event flag, LED[4:3]=0, LED[2:0]=octave registered.
REQ-028 SHALL latency from raw KEYBOARD edge to frame_valid = 2 + DEBOUNCE_CYCLES + 2 cycles when FIFO empty and no other pends.

Reset
REQ-029 SHALL on reset clear synchronisers, stable states, counters, pend bits, FIFO pointers; fifo_count=0, frame_valid=0, frame_data=10'b1_0000_0000_0.
REQ-030 SHALL on reset drive all noteFrequency to 0, LED=8'h00 (LED[2:0] included), LED[5] cleared.
REQ-031 SHALL abort any in-progress debounce on reset mid-count; keys held through reset re-debounce from zero and generate a press event afterwards.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-032 SHALL test: KEYBOARD[0]=1 held, octave=0, ready=1 -> frame_data=10'b1_0100_0011_0 (43h), noteFrequency[0]=191113; release -> 10'b1_1100_0011_0 (C3h), noteFrequency[0]=0.
REQ-033 SHALL test: KEYBOARD[3] glitch high 3 cycles -> no event, noteFrequency[3]=0.
REQ-034 SHALL test: keys 2 and 9 pressed same cycle -> frames 44h then 41h in consecutive valid cycles.
REQ-035 SHALL test: ready=0, six keys pressed -> fifo_count=4, remaining two emitted after ready=1, in index order, LED[5]=0.
REQ-036 SHALL test: key 12 held, octave 0->3 -> noteFrequency[12] 95556 -> 11944 one cycle later, LED[2:0]=3.
REQ-037 SHALL test: reset asserted mid-debounce and with FIFO non-empty -> next cycle frame_valid=0, fifo_count=0, LED=00h.
